rule_compactor: RTL and testbench
=================================

// Module: rule_compactor
// PURPOSE
//  Sits directly downstream of the port-group filter. Consumes its 64b stream of 4x16b rule-ID lanes,
//  in which filtered-out lanes are 0, and packs the non-zero IDs densely into output beats with packet
//  boundaries preserved. Feeds the non-fast-pattern matcher, so that matcher stops wasting cycles on
//  empty lanes.
// PARAMETERS
//  LANE_WIDTH  16  bits per rule-ID lane; value 0 = no rule
//  NUM_LANES   4   lanes per beat; only 4 is supported (data 64b, empty 3b)
//  CNT_WIDTH   32  width of stats counters
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous, active-high reset
//  in_data        in   64  lane i = bits [16i+15:16i]; lane 0 is oldest
//  in_valid       in   1   input beat valid
//  in_sop         in   1   first beat of packet (informational; sop is regenerated)
//  in_eop         in   1   last beat of packet
//  in_empty       in   3   ignored
//  in_ready       out  1   input accept
//  out_data       out  64  packed rule IDs, lane 0 oldest; unused lanes 0
//  out_valid      out  1   output beat valid
//  out_sop        out  1   first output beat of packet
//  out_eop        out  1   last output beat of packet
//  out_empty      out  3   2*(4-n) bytes, where n = valid lanes in the beat
//  out_ready      in   1   output accept
//  rule_in_cnt    out  32  non-zero lanes accepted
//  rule_out_cnt   out  32  lanes emitted with an ID
//  pkt_cnt        out  32  eop beats emitted
// BEHAVIOUR
//  - Reset: out_valid=0, out_sop=0, out_eop=0, out_data=0, out_empty=0, in_ready=0, all counters=0,
//    buffer count=0, state=RUN, first flag=1.
//  - Reset mid-packet discards buffered IDs. No beat of the aborted packet is emitted after reset.
//  - Accept: in_valid & in_ready.
//    - Non-zero lanes are compacted in lane order and appended to a holding buffer of 0..3 entries.
//    - 4 new + 3 held = at most 7 entries.
//  - Output is a single register stage. Latency is 1 cycle from accept to out_valid.
//  - Emit rules:
//    - Not eop and total >= 4: the oldest 4 form a full beat (empty=0); the rest (0..3) stay held.
//    - Not eop and total < 4: no beat is emitted; all entries are held.
//    - eop and total <= 4: one beat with eop=1 and out_empty=2*(4-total); buffer is cleared.
//    - eop and total 5..7: a full beat with eop=0 is emitted; the remainder is held; state moves
//      RUN->FLUSH.
//  - FLUSH state: in_ready=0. When the output register is free, emit the remainder with eop=1,
//    then return to RUN.
//  - Zero-rule packet (eop with total=0): one beat, out_data=0, sop=eop=1, out_empty=0.
//    Downstream treats ID 0 as null.
//  - out_sop=1 on the first beat emitted while the first flag is set. The flag clears on that beat
//    and sets again after the eop beat is emitted.
//  - in_ready = (state==RUN) & (!out_valid | out_ready).
//  - The output register holds data stable while out_valid & !out_ready.
//  - Back-to-back packets run at full rate except for one FLUSH cycle when total > 4 at eop.
//  - Counters wrap modulo 2^CNT_WIDTH. rule_out_cnt never counts the zero-rule beat.
// CONFIGURATION
//  RULE_DEDUP_EN defined:
//   - Within a packet, a non-zero ID equal to the previously appended ID is dropped. The compare is
//     sequential across lanes and beats.
//   - The last-ID register clears at eop and at reset.
//   - rule_in_cnt still counts dropped IDs.
//  RULE_DEDUP_EN undefined: every non-zero lane is forwarded; no compare logic is built.
// TESTING
//  - 1 beat {0,7,0,9} eop -> 1 beat: lane0=7, lane1=9, sop=eop=1, empty=4; pkt_cnt=1.
//  - Beats {1,2,3,0},{4,5,6,7} eop -> beat {1,2,3,4} sop; FLUSH; beat {5,6,7,0} eop, empty=2;
//    in_ready=0 for 1 cycle.
//  - Beat {0,0,0,0} eop -> 1 beat, data=0, sop=eop=1, empty=0; rule_out_cnt unchanged.
//  - out_ready=0 for 5 cycles mid-packet -> out_data stable, in_ready=0, no ID lost or duplicated;
//    scoreboard matches.
//  - rst asserted while 3 IDs are held -> next cycle out_valid=0, all counters=0; next packet starts
//    with sop.
//  - RULE_DEDUP_EN: beats {5,5,0,6},{6,6,8,0} eop -> 1 beat {5,6,8,0} eop, empty=2;
//    without the macro -> {5,5,6,6} then {6,8,0,0} eop, empty=4.

Source files
------------

// File: rtl/rule_compactor.sv
// -----------------------------------------------------------------------------
// rule_compactor
//
// Packs the non-zero 16b rule IDs of a 4-lane stream densely into output beats,
// keeping packet boundaries. Lane 0 is the oldest lane on both sides. Up to three
// IDs are carried between input beats in a holding buffer. When an end-of-packet
// beat leaves more than four IDs, one extra FLUSH cycle emits the remainder.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   in_data/valid/sop/eop/empty/ready
//                   upstream stream (in_sop and in_empty are not needed: sop is
//                   regenerated and the zero lanes already mark unused slots)
//   out_data/valid/sop/eop/empty/ready
//                   packed downstream stream, out_empty = 2*(4-n) bytes
//   rule_in_cnt     non-zero lanes accepted
//   rule_out_cnt    ID lanes delivered downstream
//   pkt_cnt         eop beats delivered downstream
//
// Configuration macro
//   RULE_DEDUP_EN   when defined, an ID equal to the previously appended ID of
//                   the same packet is dropped (sequential across lanes/beats).
// -----------------------------------------------------------------------------
module rule_compactor #(
    parameter int LANE_WIDTH = 16,
    parameter int NUM_LANES  = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [LANE_WIDTH*NUM_LANES-1:0]  in_data,
    input  logic                             in_valid,
    input  logic                             in_sop,
    input  logic                             in_eop,
    input  logic [2:0]                       in_empty,
    output logic                             in_ready,
    output logic [LANE_WIDTH*NUM_LANES-1:0]  out_data,
    output logic                             out_valid,
    output logic                             out_sop,
    output logic                             out_eop,
    output logic [2:0]                       out_empty,
    input  logic                             out_ready,
    output logic [CNT_WIDTH-1:0]             rule_in_cnt,
    output logic [CNT_WIDTH-1:0]             rule_out_cnt,
    output logic [CNT_WIDTH-1:0]             pkt_cnt
);

    localparam int DATA_W = LANE_WIDTH * NUM_LANES;
    localparam int HOLD_W = LANE_WIDTH * 3;
    localparam int COMB_W = LANE_WIDTH * 7;

    typedef enum logic {RUN, FLUSH} state_t;

    state_t                state;
    state_t                next_state;

    logic [HOLD_W-1:0]     hold_data;
    logic [HOLD_W-1:0]     hold_data_nxt;
    logic [1:0]            hold_cnt;
    logic [1:0]            hold_cnt_nxt;
    logic                  first_flag;

    logic                  out_free;
    logic                  accept;

    logic [LANE_WIDTH-1:0] lane;
    logic                  keep;
    logic [DATA_W-1:0]     new_data;
    logic [2:0]            new_cnt;
    logic [2:0]            in_nz_cnt;
    logic [2:0]            out_nz_cnt;
    logic [2:0]            total;
    logic [COMB_W-1:0]     comb_data;

    logic                  load;
    logic [DATA_W-1:0]     load_data;
    logic                  load_eop;
    logic [2:0]            load_empty;

    logic                  unused_inputs;

`ifdef RULE_DEDUP_EN
    logic [LANE_WIDTH-1:0] last_id;
    logic [LANE_WIDTH-1:0] last_id_nxt;
`endif

    assign unused_inputs = ^{in_sop, in_empty};

    // Bytes of padding for a beat carrying n IDs; the zero-rule beat reports 0.
    function automatic logic [2:0] empty_for(input logic [2:0] n);
        case (n)
            3'd1:    empty_for = 3'd6;
            3'd2:    empty_for = 3'd4;
            3'd3:    empty_for = 3'd2;
            default: empty_for = 3'd0;
        endcase
    endfunction

    assign out_free = !out_valid || out_ready;

    // Compact the non-zero lanes of the incoming beat into new_data[0..new_cnt-1].
    // With dedup, the running last ID is threaded through the lanes in order.
    always_comb begin
        new_data  = '0;
        new_cnt   = '0;
        in_nz_cnt = '0;
        lane      = '0;
        keep      = 1'b0;
`ifdef RULE_DEDUP_EN
        last_id_nxt = last_id;
`endif
        for (int i = 0; i < NUM_LANES; i++) begin
            lane = in_data[i*LANE_WIDTH +: LANE_WIDTH];
            keep = (lane != '0);
            if (keep) begin
                in_nz_cnt = in_nz_cnt + 3'd1;
            end
`ifdef RULE_DEDUP_EN
            keep = keep && (lane != last_id_nxt);
            if (keep) begin
                last_id_nxt = lane;
            end
`endif
            if (keep) begin
                new_data[new_cnt[1:0]*LANE_WIDTH +: LANE_WIDTH] = lane;
                new_cnt = new_cnt + 3'd1;
            end
        end
    end

    // Held IDs sit below the new ones; unused held slots are kept at zero so
    // everything above 'total' entries is zero as well.
    assign comb_data = {{(COMB_W-HOLD_W){1'b0}}, hold_data}
                     | ({{(COMB_W-DATA_W){1'b0}}, new_data} << (hold_cnt * LANE_WIDTH));
    assign total     = {1'b0, hold_cnt} + new_cnt;

    always_comb begin
        out_nz_cnt = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (out_data[i*LANE_WIDTH +: LANE_WIDTH] != '0) begin
                out_nz_cnt = out_nz_cnt + 3'd1;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // FSM: next state
    always_comb begin
        next_state = state;
        case (state)
            RUN: begin
                if (accept && in_eop && (total > 3'd4)) begin
                    next_state = FLUSH;
                end
            end
            FLUSH: begin
                if (out_free) begin
                    next_state = RUN;
                end
            end
            default: next_state = RUN;
        endcase
    end

    // FSM: outputs, i.e. input handshake and what goes into the output register
    always_comb begin
        in_ready      = !rst && (state == RUN) && out_free;
        accept        = in_valid && in_ready;
        load          = 1'b0;
        load_data     = comb_data[DATA_W-1:0];
        load_eop      = 1'b0;
        load_empty    = 3'd0;
        hold_data_nxt = hold_data;
        hold_cnt_nxt  = hold_cnt;
        case (state)
            RUN: begin
                if (accept) begin
                    if (in_eop && (total <= 3'd4)) begin
                        load          = 1'b1;
                        load_eop      = 1'b1;
                        load_empty    = empty_for(total);
                        hold_data_nxt = '0;
                        hold_cnt_nxt  = '0;
                    end else if (total >= 3'd4) begin
                        // Full beat; on eop with 5..7 the remainder waits for FLUSH.
                        load          = 1'b1;
                        hold_data_nxt = comb_data[COMB_W-1:DATA_W];
                        hold_cnt_nxt  = 2'(total - 3'd4);
                    end else begin
                        hold_data_nxt = comb_data[HOLD_W-1:0];
                        hold_cnt_nxt  = total[1:0];
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    load          = 1'b1;
                    load_data     = {{(DATA_W-HOLD_W){1'b0}}, hold_data};
                    load_eop      = 1'b1;
                    load_empty    = empty_for({1'b0, hold_cnt});
                    hold_data_nxt = '0;
                    hold_cnt_nxt  = '0;
                end
            end
            default: ;
        endcase
    end

    // Datapath: holding buffer, output register, sop tracking and counters.
    // A beat is only loaded while the output register is free, so a stalled
    // beat stays untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_data    <= '0;
            hold_cnt     <= '0;
            first_flag   <= 1'b1;
            out_valid    <= 1'b0;
            out_sop      <= 1'b0;
            out_eop      <= 1'b0;
            out_data     <= '0;
            out_empty    <= '0;
            rule_in_cnt  <= '0;
            rule_out_cnt <= '0;
            pkt_cnt      <= '0;
`ifdef RULE_DEDUP_EN
            last_id      <= '0;
`endif
        end else begin
            hold_data <= hold_data_nxt;
            hold_cnt  <= hold_cnt_nxt;
            if (out_free) begin
                out_valid <= load;
                if (load) begin
                    out_data   <= load_data;
                    out_sop    <= first_flag;
                    out_eop    <= load_eop;
                    out_empty  <= load_empty;
                    first_flag <= load_eop;
                end
            end
            if (accept) begin
                rule_in_cnt <= rule_in_cnt + CNT_WIDTH'(in_nz_cnt);
            end
            if (out_valid && out_ready) begin
                rule_out_cnt <= rule_out_cnt + CNT_WIDTH'(out_nz_cnt);
                if (out_eop) begin
                    pkt_cnt <= pkt_cnt + 1'b1;
                end
            end
`ifdef RULE_DEDUP_EN
            if (accept) begin
                last_id <= in_eop ? '0 : last_id_nxt;
            end
`endif
        end
    end

endmodule

// File: tb/tb_rule_compactor.sv
// -----------------------------------------------------------------------------
// tb_rule_compactor
//
// Drives rule_compactor with directed and random packets. A packet-level model
// (queue of pending IDs, queue of expected output beats) predicts every output
// beat, the input-ready behaviour and the counters; one compare process checks
// the DUT against it on every falling edge. Directed scenarios additionally pin
// delivered beats to hand-computed literals.
// -----------------------------------------------------------------------------
module tb_rule_compactor;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] in_data;
    logic        in_valid;
    logic        in_sop;
    logic        in_eop;
    logic [2:0]  in_empty;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_sop;
    logic        out_eop;
    logic [2:0]  out_empty;
    logic        out_ready;
    logic [31:0] rule_in_cnt;
    logic [31:0] rule_out_cnt;
    logic [31:0] pkt_cnt;

    always #5 clk = ~clk;

    rule_compactor dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_sop       (in_sop),
        .in_eop       (in_eop),
        .in_empty     (in_empty),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_sop      (out_sop),
        .out_eop      (out_eop),
        .out_empty    (out_empty),
        .out_ready    (out_ready),
        .rule_in_cnt  (rule_in_cnt),
        .rule_out_cnt (rule_out_cnt),
        .pkt_cnt      (pkt_cnt)
    );

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic [2:0]  empty;
        int          n;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       seen_q[$];
    logic [15:0] pend_q[$];
    logic        m_first;
    logic [15:0] m_last;
    int unsigned m_rin;
    int unsigned m_rout;
    int unsigned m_pkt;

    int compared   = 0;
    int mismatched = 0;
    int bp_mode    = 0;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic failNow(input string name);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    function automatic logic [63:0] mk(input logic [15:0] l0, input logic [15:0] l1,
                                       input logic [15:0] l2, input logic [15:0] l3);
        return {l3, l2, l1, l0};
    endfunction

    task automatic modelReset();
        exp_q.delete();
        pend_q.delete();
        m_first = 1'b1;
        m_last  = '0;
        m_rin   = 0;
        m_rout  = 0;
        m_pkt   = 0;
    endtask

    task automatic modelEmit(input int n, input logic eop);
        beat_t b;
        b.data = '0;
        for (int k = 0; k < n; k++) begin
            b.data[k*16 +: 16] = pend_q.pop_front();
        end
        b.n     = n;
        b.empty = (n == 0) ? 3'd0 : 3'(2 * (4 - n));
        b.sop   = m_first;
        b.eop   = eop;
        m_first = eop;
        exp_q.push_back(b);
    endtask

    // Packet-level rule: IDs queue up in arrival order; full beats leave as soon
    // as four are present, except that at eop a final beat of up to four closes
    // the packet.
    task automatic modelAccept(input logic [63:0] d, input logic eop);
        logic [15:0] id;
        for (int i = 0; i < 4; i++) begin
            id = d[i*16 +: 16];
            if (id != 16'd0) begin
                m_rin++;
`ifdef RULE_DEDUP_EN
                if (id != m_last) begin
                    pend_q.push_back(id);
                    m_last = id;
                end
`else
                pend_q.push_back(id);
`endif
            end
        end
        if (!eop) begin
            while (pend_q.size() >= 4) modelEmit(4, 1'b0);
        end else begin
            while (pend_q.size() > 4) modelEmit(4, 1'b0);
            modelEmit(pend_q.size(), 1'b1);
            m_last = '0;
        end
    endtask

    // Per-cycle compare, then advance the model for the coming rising edge.
    always @(negedge clk) begin
        logic  exp_ready;
        beat_t act;
        if (rst) begin
            checkOutput("in_ready_in_reset", {63'd0, in_ready}, 64'd0);
            modelReset();
        end else begin
            checkOutput("out_valid", {63'd0, out_valid}, {63'd0, exp_q.size() > 0});
            if (out_valid && (exp_q.size() > 0)) begin
                checkOutput("out_data",  out_data, exp_q[0].data);
                checkOutput("out_sop",   {63'd0, out_sop}, {63'd0, exp_q[0].sop});
                checkOutput("out_eop",   {63'd0, out_eop}, {63'd0, exp_q[0].eop});
                checkOutput("out_empty", {61'd0, out_empty}, {61'd0, exp_q[0].empty});
            end
            exp_ready = (exp_q.size() == int'(out_valid)) && (!out_valid || out_ready);
            checkOutput("in_ready", {63'd0, in_ready}, {63'd0, exp_ready});
            checkOutput("rule_in_cnt",  {32'd0, rule_in_cnt},  {32'd0, m_rin});
            checkOutput("rule_out_cnt", {32'd0, rule_out_cnt}, {32'd0, m_rout});
            checkOutput("pkt_cnt",      {32'd0, pkt_cnt},      {32'd0, m_pkt});
            if (out_valid && out_ready) begin
                act.data  = out_data;
                act.sop   = out_sop;
                act.eop   = out_eop;
                act.empty = out_empty;
                act.n     = 0;
                seen_q.push_back(act);
                if (exp_q.size() > 0) begin
                    m_rout += exp_q[0].n;
                    if (exp_q[0].eop) m_pkt++;
                    void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                modelAccept(in_data, in_eop);
            end
        end
    end

    // Output back-pressure: 0 = always ready, 1 = random, 2 = stalled
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (bp_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ($urandom_range(0, 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    task automatic applyStimulus(input logic [63:0] d, input logic eop, input logic sop);
        logic acc;
        acc      = 1'b0;
        in_data  = d;
        in_eop   = eop;
        in_sop   = sop;
        in_empty = 3'd0;
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) break;
        end
        if (!acc) failNow("accept_timeout");
        in_valid = 1'b0;
    endtask

    task automatic drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!done) failNow("drain_timeout");
    endtask

    task automatic checkBeat(input string name, input int idx, input logic [63:0] d,
                             input logic sop, input logic eop, input logic [2:0] empty);
        if (seen_q.size() > idx) begin
            checkOutput({name, "_data"},  seen_q[idx].data, d);
            checkOutput({name, "_sop"},   {63'd0, seen_q[idx].sop}, {63'd0, sop});
            checkOutput({name, "_eop"},   {63'd0, seen_q[idx].eop}, {63'd0, eop});
            checkOutput({name, "_empty"}, {61'd0, seen_q[idx].empty}, {61'd0, empty});
        end else begin
            failNow({name, "_missing"});
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int          base;
        logic [31:0] rout0;
        logic [63:0] d;
        logic        eop;
        logic        sop;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        in_empty = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_out_valid", {63'd0, out_valid}, 64'd0);
        checkOutput("reset_in_ready",  {63'd0, in_ready},  64'd1);
        @(posedge clk);
        #1;

        $display("[TB] two IDs in one eop beat");
        base = seen_q.size();
        applyStimulus(mk(0, 7, 0, 9), 1'b1, 1'b1);
        drain();
        checkBeat("t1", base, 64'h0000_0000_0009_0007, 1'b1, 1'b1, 3'd4);
        checkOutput("t1_pkt_cnt", {32'd0, pkt_cnt}, 64'd1);

        $display("[TB] seven IDs at eop force a flush beat");
        base = seen_q.size();
        applyStimulus(mk(1, 2, 3, 0), 1'b0, 1'b1);
        applyStimulus(mk(4, 5, 6, 7), 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t2_ready_in_flush", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        checkOutput("t2_ready_after_flush", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        drain();
        checkBeat("t2a", base,     64'h0004_0003_0002_0001, 1'b1, 1'b0, 3'd0);
        checkBeat("t2b", base + 1, 64'h0000_0007_0006_0005, 1'b0, 1'b1, 3'd2);

        $display("[TB] zero-rule packet");
        base  = seen_q.size();
        rout0 = rule_out_cnt;
        applyStimulus(mk(0, 0, 0, 0), 1'b1, 1'b1);
        drain();
        checkBeat("t3", base, 64'h0, 1'b1, 1'b1, 3'd0);
        checkOutput("t3_rule_out_cnt", {32'd0, rule_out_cnt}, {32'd0, rout0});

        $display("[TB] output stalled for five cycles");
        base    = seen_q.size();
        bp_mode = 2;
        repeat (2) @(posedge clk);
        #2;
        applyStimulus(mk(1, 2, 3, 4), 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("t4_stall_valid", {63'd0, out_valid}, 64'd1);
            checkOutput("t4_stall_data",  out_data, 64'h0004_0003_0002_0001);
            checkOutput("t4_stall_ready", {63'd0, in_ready}, 64'd0);
        end
        @(posedge clk);
        #1;
        bp_mode = 0;
        applyStimulus(mk(5, 0, 6, 0), 1'b1, 1'b0);
        drain();
        checkBeat("t4a", base,     64'h0004_0003_0002_0001, 1'b1, 1'b0, 3'd0);
        checkBeat("t4b", base + 1, 64'h0000_0000_0006_0005, 1'b0, 1'b1, 3'd4);

        $display("[TB] reset while three IDs are held");
        applyStimulus(mk(1, 0, 2, 3), 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t5_out_valid",    {63'd0, out_valid}, 64'd0);
        checkOutput("t5_rule_in_cnt",  {32'd0, rule_in_cnt}, 64'd0);
        checkOutput("t5_rule_out_cnt", {32'd0, rule_out_cnt}, 64'd0);
        checkOutput("t5_pkt_cnt",      {32'd0, pkt_cnt}, 64'd0);
        @(posedge clk);
        #1;
        base = seen_q.size();
        applyStimulus(mk(0, 0, 9, 0), 1'b1, 1'b1);
        drain();
        checkBeat("t5", base, 64'h0000_0000_0000_0009, 1'b1, 1'b1, 3'd6);

        $display("[TB] repeated IDs across lanes and beats");
        base = seen_q.size();
        applyStimulus(mk(5, 5, 0, 6), 1'b0, 1'b1);
        applyStimulus(mk(6, 6, 8, 0), 1'b1, 1'b0);
        drain();
`ifdef RULE_DEDUP_EN
        checkBeat("t6", base, 64'h0000_0008_0006_0005, 1'b1, 1'b1, 3'd2);
`else
        checkBeat("t6a", base,     64'h0006_0006_0005_0005, 1'b1, 1'b0, 3'd0);
        checkBeat("t6b", base + 1, 64'h0000_0000_0008_0006, 1'b0, 1'b1, 3'd4);
`endif

        $display("[TB] random packets with random back-pressure");
        bp_mode = 1;
        sop     = 1'b1;
        for (int b = 0; b < 400; b++) begin
            d = '0;
            for (int l = 0; l < 4; l++) begin
                if ($urandom_range(0, 1) != 0) d[l*16 +: 16] = 16'($urandom_range(1, 3));
            end
            eop = ($urandom_range(0, 3) == 0);
            applyStimulus(d, eop, sop);
            sop = eop;
            if ($urandom_range(0, 7) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        applyStimulus(mk(1, 2, 3, 1), 1'b1, sop);
        bp_mode = 0;
        drain();
        repeat (3) @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
